// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit with store-queue forwarding.
package lsu_pkg;

  // Instruction codes as used by the decode stage (instr_defines.vh)
  localparam logic [5:0] INSTR_LB  = 6'd1;
  localparam logic [5:0] INSTR_LH  = 6'd2;
  localparam logic [5:0] INSTR_LW  = 6'd3;
  localparam logic [5:0] INSTR_LBU = 6'd4;
  localparam logic [5:0] INSTR_LHU = 6'd5;
  localparam logic [5:0] INSTR_SB  = 6'd6;
  localparam logic [5:0] INSTR_SH  = 6'd7;
  localparam logic [5:0] INSTR_SW  = 6'd8;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [2:0] {
    L_IDLE = 3'd0,
    L_REQ  = 3'd1,
    L_WAIT = 3'd2,
    L_DONE = 3'd3,
    L_HOLD = 3'd4
  } lstate_e;

  // Low two bits double as the access size
  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101
  } ld_type_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  function automatic logic [LANES-1:0] be_for(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_B:    be_for = 4'(4'b0001 << off);
      SZ_H:    be_for = 4'(4'b0011 << off);
      default: be_for = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_shift(input size_e sz, input logic [DATA_W-1:0] data);
    case (sz)
      SZ_B:    lane_shift = {4{data[7:0]}};
      SZ_H:    lane_shift = {2{data[15:0]}};
      default: lane_shift = data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_sq.sv
// Circular store queue with per-lane youngest-match forwarding lookup.
module lsu_sq
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-3:0] push_word,
  input  logic [DATA_W-1:0] push_data,
  input  logic [LANES-1:0]  push_be,
  input  logic              pop_ready,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-3:0] head_word,
  output logic [DATA_W-1:0] head_data,
  output logic [LANES-1:0]  head_be,
  input  logic [ADDR_W-3:0] look_word,
  output logic [LANES-1:0]  fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              any_match
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned WORD_W = ADDR_W - 2;

  logic [WORD_W-1:0] word_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [LANES-1:0]  be_q   [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [PTR_W-1:0]  count;
  logic [IDX_W-1:0]  idx;
  logic              push_ok;
  logic              pop;

  assign count   = tail_q - head_q;
  assign empty   = (head_q == tail_q);
  assign full    = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                   (head_q[PTR_W-1] != tail_q[PTR_W-1]);
  assign push_ok = push && !full;
  assign pop     = pop_ready && !empty;

  assign head_word = word_q[head_q[IDX_W-1:0]];
  assign head_data = data_q[head_q[IDX_W-1:0]];
  assign head_be   = be_q[head_q[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (push_ok) begin
        word_q[tail_q[IDX_W-1:0]] <= push_word;
        data_q[tail_q[IDX_W-1:0]] <= push_data;
        be_q[tail_q[IDX_W-1:0]]   <= push_be;
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
    end
  end

  // Walk oldest to youngest so the youngest match per lane wins
  always_comb begin
    fwd_hit   = '0;
    fwd_data  = '0;
    any_match = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q[IDX_W-1:0] + IDX_W'(i);
      if ((PTR_W'(i) < count) && (word_q[idx] == look_word)) begin
        any_match = 1'b1;
        for (int unsigned l = 0; l < LANES; l++) begin
          if (be_q[idx][l]) begin
            fwd_hit[l]          = 1'b1;
            fwd_data[8*l +: 8]  = data_q[idx][8*l +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/lsu_store_queue_fwd.sv
// MEM-stage load/store unit: decode, alignment check, store enqueue, load FSM with
// store-queue forwarding and memory fallback, load extension.
module lsu_store_queue_fwd
  import lsu_pkg::*;
#(
  parameter int unsigned SQ_DEPTH = 4,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              cache_stall,
  input  logic [5:0]        instr_id,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       rs2_value,
  output logic              lsu_busy,
  output logic              misalign_fault,
  output logic              load_done,
  output logic [31:0]       load_data,
  output logic              sq_empty,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_byte_en,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data_valid,
  input  logic [31:0]       rd_data
);

  localparam int unsigned WORD_W = ADDR_W - 2;

  lstate_e           state_q;
  lstate_e           state_d;
  logic              is_load;
  logic              is_store;
  size_e             sz;
  ld_type_e          ld_type;
  logic              misalign;
  logic              accept;
  logic              store_go;
  logic              load_go;
  logic              sq_full;
  logic [WORD_W-1:0] head_word;
  logic [WORD_W-1:0] look_word;
  logic [3:0]        fwd_hit;
  logic [31:0]       fwd_data;
  logic              any_match;
  logic [3:0]        req_be;
  logic [3:0]        hit_req;
  logic [ADDR_W-1:0] lat_addr_q;
  ld_type_e          lat_type_q;
  logic [31:0]       load_data_q;
  logic [31:0]       load_data_d;
  logic              load_done_q;
  logic              rd_valid_q;
  logic              misalign_q;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input ld_type_e t,
                                              input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (t)
      LT_LB:   load_extend = {{24{sh[7]}}, sh[7:0]};
      LT_LH:   load_extend = {{16{sh[15]}}, sh[15:0]};
      LT_LBU:  load_extend = {24'h0, sh[7:0]};
      LT_LHU:  load_extend = {16'h0, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  // Instruction decode
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz       = SZ_W;
    ld_type  = LT_LW;
    case (instr_id)
      INSTR_LB:  begin is_load = 1'b1;  sz = SZ_B; ld_type = LT_LB;  end
      INSTR_LH:  begin is_load = 1'b1;  sz = SZ_H; ld_type = LT_LH;  end
      INSTR_LW:  begin is_load = 1'b1;  sz = SZ_W; ld_type = LT_LW;  end
      INSTR_LBU: begin is_load = 1'b1;  sz = SZ_B; ld_type = LT_LBU; end
      INSTR_LHU: begin is_load = 1'b1;  sz = SZ_H; ld_type = LT_LHU; end
      INSTR_SB:  begin is_store = 1'b1; sz = SZ_B; end
      INSTR_SH:  begin is_store = 1'b1; sz = SZ_H; end
      INSTR_SW:  begin is_store = 1'b1; sz = SZ_W; end
      default:   ;
    endcase
  end

  assign misalign = ((sz == SZ_H) && mem_addr[0]) ||
                    ((sz == SZ_W) && (mem_addr[1:0] != 2'b00));
  assign lsu_busy = (state_q != L_IDLE) || (valid_in && is_store && sq_full);
  assign accept   = valid_in && !cache_stall && !lsu_busy && (is_load || is_store);
  assign store_go = accept && is_store && !misalign;
  assign load_go  = accept && is_load && !misalign;

  // Latched address drives the lookup while a load is in flight
  assign look_word = (state_q == L_IDLE) ? mem_addr[ADDR_W-1:2] : lat_addr_q[ADDR_W-1:2];
  assign req_be    = be_for(sz, mem_addr[1:0]);
  assign hit_req   = fwd_hit & req_be;

  lsu_sq #(
    .DEPTH  (SQ_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sq (
    .clk       (clk),
    .rst       (rst),
    .push      (store_go),
    .push_word (mem_addr[ADDR_W-1:2]),
    .push_data (lane_shift(sz, rs2_value)),
    .push_be   (be_for(sz, mem_addr[1:0])),
    .pop_ready (wr_ready),
    .full      (sq_full),
    .empty     (sq_empty),
    .head_word (head_word),
    .head_data (wr_data),
    .head_be   (wr_byte_en),
    .look_word (look_word),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .any_match (any_match)
  );

  assign wr_valid = !sq_empty;
  assign wr_addr  = {head_word, 2'b00};

  // Load FSM next state and load result
  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    case (state_q)
      L_IDLE: begin
        if (load_go) begin
          if (hit_req == req_be) begin
            state_d     = L_DONE;
            load_data_d = load_extend(fwd_data, ld_type, mem_addr[1:0]);
          end else if (hit_req == 4'b0000) begin
            state_d = L_REQ;
          end else begin
            state_d = L_HOLD;
          end
        end
      end
      L_HOLD: if (!any_match) state_d = L_REQ;
      L_REQ:  if (rd_ready) state_d = L_WAIT;
      L_WAIT: begin
        if (rd_data_valid) begin
          state_d     = L_DONE;
          load_data_d = load_extend(rd_data, lat_type_q, lat_addr_q[1:0]);
        end
      end
      L_DONE:  state_d = L_IDLE;
      default: state_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= L_IDLE;
      lat_addr_q  <= '0;
      lat_type_q  <= LT_LW;
      load_data_q <= '0;
      load_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
      load_done_q <= (state_d == L_DONE);
      rd_valid_q  <= (state_d == L_REQ);
      misalign_q  <= accept && misalign;
      if (load_go) begin
        lat_addr_q <= mem_addr;
        lat_type_q <= ld_type;
      end
    end
  end

  assign load_done      = load_done_q;
  assign load_data      = load_data_q;
  assign rd_valid       = rd_valid_q;
  assign rd_addr        = {lat_addr_q[ADDR_W-1:2], 2'b00};
  assign misalign_fault = misalign_q;

endmodule

// File: tb/tb_lsu_store_queue_fwd.sv
// Directed bench for lsu_store_queue_fwd: store/forward vector table plus multi-cycle sequences.
module tb_lsu_store_queue_fwd;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        cache_stall;
  logic [5:0]  instr_id;
  logic [31:0] mem_addr;
  logic [31:0] rs2_value;
  logic        lsu_busy;
  logic        misalign_fault;
  logic        load_done;
  logic [31:0] load_data;
  logic        sq_empty;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_byte_en;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_addr;
  logic        rd_data_valid;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  lsu_store_queue_fwd #(.SQ_DEPTH(4), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .cache_stall    (cache_stall),
    .instr_id       (instr_id),
    .mem_addr       (mem_addr),
    .rs2_value      (rs2_value),
    .lsu_busy       (lsu_busy),
    .misalign_fault (misalign_fault),
    .load_done      (load_done),
    .load_data      (load_data),
    .sq_empty       (sq_empty),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_byte_en     (wr_byte_en),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_addr        (rd_addr),
    .rd_data_valid  (rd_data_valid),
    .rd_data        (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] exp_wr_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wr_data;
    logic [5:0]  ld_op;
    logic [31:0] ld_addr;
    logic [31:0] exp_ld;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
    valid_in  = 1'b1;
    instr_id  = op;
    mem_addr  = addr;
    rs2_value = data;
  endtask

  task automatic idle();
    valid_in  = 1'b0;
    instr_id  = 6'd0;
    mem_addr  = 32'hFFFF_FFFF;
    rs2_value = 32'h0;
  endtask

  initial begin
    vecs[0] = '{INSTR_SB, 32'h1003, 32'h0000_00AB, 32'h1000, 4'b1000, 32'hABAB_ABAB,
                INSTR_LBU, 32'h1003, 32'h0000_00AB};
    vecs[1] = '{INSTR_SW, 32'h2000, 32'h8081_8283, 32'h2000, 4'b1111, 32'h8081_8283,
                INSTR_LB, 32'h2001, 32'hFFFF_FF82};
    vecs[2] = '{INSTR_SH, 32'h2402, 32'h1234_F00D, 32'h2400, 4'b1100, 32'hF00D_F00D,
                INSTR_LH, 32'h2402, 32'hFFFF_F00D};
    vecs[3] = '{INSTR_SH, 32'h2400, 32'h0000_8001, 32'h2400, 4'b0011, 32'h8001_8001,
                INSTR_LHU, 32'h2400, 32'h0000_8001};
    vecs[4] = '{INSTR_SB, 32'h2501, 32'hFFFF_FF7E, 32'h2500, 4'b0010, 32'h7E7E_7E7E,
                INSTR_LB, 32'h2501, 32'h0000_007E};
    vecs[5] = '{INSTR_SW, 32'h2600, 32'hDEAD_BEEF, 32'h2600, 4'b1111, 32'hDEAD_BEEF,
                INSTR_LW, 32'h2600, 32'hDEAD_BEEF};
    vecs[6] = '{INSTR_SW, 32'h2700, 32'h0000_C3A5, 32'h2700, 4'b1111, 32'h0000_C3A5,
                INSTR_LB, 32'h2700, 32'hFFFF_FFA5};

    rst = 1'b1;
    cache_stall = 1'b0;
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    rd_data_valid = 1'b0;
    rd_data = 32'h0;
    idle();
    repeat (2) tick();
    chk("reset_wr_valid", 32'(wr_valid), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_load_done", 32'(load_done), 32'd0);
    chk("reset_load_data", load_data, 32'h0);
    chk("reset_busy", 32'(lsu_busy), 32'd0);
    chk("reset_sq_empty", 32'(sq_empty), 32'd1);
    rst = 1'b0;
    tick();

    // Store then forwarded load, then drain
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].st_op, vecs[i].st_addr, vecs[i].st_data);
      tick();
      idle();
      chk($sformatf("v%0d_wr_valid", i), 32'(wr_valid), 32'd1);
      chk($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].exp_wr_addr);
      chk($sformatf("v%0d_wr_be", i), 32'(wr_byte_en), 32'(vecs[i].exp_be));
      chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].exp_wr_data);
      drive(vecs[i].ld_op, vecs[i].ld_addr, 32'h0);
      tick();
      idle();
      chk($sformatf("v%0d_load_done", i), 32'(load_done), 32'd1);
      chk($sformatf("v%0d_load_data", i), load_data, vecs[i].exp_ld);
      chk($sformatf("v%0d_no_rd", i), 32'(rd_valid), 32'd0);
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      chk($sformatf("v%0d_drained", i), 32'(sq_empty), 32'd1);
      chk($sformatf("v%0d_done_pulse", i), 32'(load_done), 32'd0);
    end

    // Partial hit waits for the drain, then reads memory
    drive(INSTR_SB, 32'h3000, 32'h11);
    tick();
    drive(INSTR_LW, 32'h3000, 32'h0);
    tick();
    idle();
    chk("partial_busy", 32'(lsu_busy), 32'd1);
    chk("partial_no_rd", 32'(rd_valid), 32'd0);
    tick();
    chk("partial_hold_rd", 32'(rd_valid), 32'd0);
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    chk("partial_popped", 32'(sq_empty), 32'd1);
    tick();
    chk("partial_rd_valid", 32'(rd_valid), 32'd1);
    chk("partial_rd_addr", rd_addr, 32'h3000);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("partial_rd_drop", 32'(rd_valid), 32'd0);
    rd_data_valid = 1'b1;
    rd_data = 32'hA5A5_A5A5;
    tick();
    rd_data_valid = 1'b0;
    chk("partial_done", 32'(load_done), 32'd1);
    chk("partial_data", load_data, 32'hA5A5_A5A5);
    tick();
    chk("partial_done_pulse", 32'(load_done), 32'd0);
    chk("partial_busy_clr", 32'(lsu_busy), 32'd0);

    // Memory load with upstream address changing while outstanding
    drive(INSTR_LH, 32'h5002, 32'h0);
    tick();
    idle();
    chk("mem_rd_valid", 32'(rd_valid), 32'd1);
    chk("mem_rd_addr", rd_addr, 32'h5000);
    tick();
    chk("mem_rd_hold", 32'(rd_valid), 32'd1);
    chk("mem_rd_addr_stable", rd_addr, 32'h5000);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    rd_data_valid = 1'b1;
    rd_data = 32'h8001_1234;
    tick();
    rd_data_valid = 1'b0;
    chk("mem_done", 32'(load_done), 32'd1);
    chk("mem_data", load_data, 32'hFFFF_8001);
    tick();

    // Full queue back-pressure and in-order drain
    for (int k = 0; k < 4; k++) begin
      drive(INSTR_SW, 32'h6000 + 32'(4 * k), 32'(k + 1));
      tick();
    end
    drive(INSTR_SW, 32'h6010, 32'd5);
    #1;
    chk("full_busy", 32'(lsu_busy), 32'd1);
    chk("full_head", wr_data, 32'd1);
    tick();
    chk("full_still_busy", 32'(lsu_busy), 32'd1);
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    #1;
    chk("full_released", 32'(lsu_busy), 32'd0);
    tick();
    idle();
    for (int k = 2; k <= 5; k++) begin
      wr_ready = 1'b1;
      #1;
      chk($sformatf("drain_%0d_valid", k), 32'(wr_valid), 32'd1);
      chk($sformatf("drain_%0d_data", k), wr_data, 32'(k));
      tick();
    end
    wr_ready = 1'b0;
    chk("drain_empty", 32'(sq_empty), 32'd1);

    // Misaligned accesses
    drive(INSTR_LW, 32'h4002, 32'h0);
    tick();
    idle();
    chk("mis_lw_fault", 32'(misalign_fault), 32'd1);
    chk("mis_lw_no_rd", 32'(rd_valid), 32'd0);
    chk("mis_lw_busy", 32'(lsu_busy), 32'd0);
    tick();
    chk("mis_lw_pulse", 32'(misalign_fault), 32'd0);
    chk("mis_lw_no_rd2", 32'(rd_valid), 32'd0);
    drive(INSTR_SH, 32'h4001, 32'h1234);
    tick();
    idle();
    chk("mis_sh_fault", 32'(misalign_fault), 32'd1);
    chk("mis_sh_not_queued", 32'(sq_empty), 32'd1);
    drive(INSTR_SB, 32'h4001, 32'h12);
    tick();
    idle();
    chk("sb_odd_no_fault", 32'(misalign_fault), 32'd0);
    chk("sb_odd_queued", 32'(sq_empty), 32'd0);
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;

    // Cache stall blocks acceptance
    cache_stall = 1'b1;
    drive(INSTR_SW, 32'h4100, 32'h77);
    tick();
    idle();
    cache_stall = 1'b0;
    chk("stall_not_queued", 32'(sq_empty), 32'd1);

    // Reset mid-load with a store pending
    drive(INSTR_SW, 32'h7100, 32'h55);
    tick();
    drive(INSTR_LW, 32'h7000, 32'h0);
    tick();
    idle();
    chk("rst_pre_rd_valid", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_misalign", 32'(misalign_fault), 32'd0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_busy", 32'(lsu_busy), 32'd0);
    chk("rst_sq_empty", 32'(sq_empty), 32'd1);
    rd_data_valid = 1'b1;
    rd_data = 32'h1234_5678;
    tick();
    rd_data_valid = 1'b0;
    chk("rst_late_data", 32'(load_done), 32'd0);
    tick();
    chk("rst_late_data2", 32'(load_done), 32'd0);
    chk("rst_late_busy", 32'(lsu_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
